half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of operands A/B and results C/S (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: A  input  WIDTH  addend operand A.
REQ-005 Port: B  input  WIDTH  addend operand B.
REQ-006 Port: in_valid  input  1  A/B qualify this cycle.
REQ-007 Port: C  output  WIDTH  registered per-bit carry.
REQ-008 Port: S  output  WIDTH  registered per-bit sum.
REQ-009 Port: out_valid  output  1  C/S hold a result produced from a valid input.
REQ-010 Port: carry_cnt  output  16  carry-event counter; present only when HALF_ADDER_CARRY_CNT_EN is defined.

Function
REQ-011 Per bit i, SHALL compute S[i] = A[i] XOR B[i], C[i] = A[i] AND B[i]; no carry propagation between bits.
REQ-012 Latency SHALL be exactly 1 clock: result of inputs sampled at edge k appears on C/S/out_valid after edge k.
REQ-013 On an edge with in_valid=1, C/S SHALL load the new results and out_valid SHALL go 1.
REQ-014 On an edge with in_valid=0, out_valid SHALL go 0 and C/S SHALL hold their previous values.
REQ-015 Back-to-back valid inputs SHALL produce back-to-back results, one per cycle, no stall; no ready/backpressure exists.
REQ-016 Truth table (WIDTH=1): A,B = 00 -> C,S=00; 01 -> 01; 10 -> 01; 11 -> 10.
REQ-017 Outputs SHALL be driven only from flops; no combinational path from A/B/in_valid to any output.
REQ-018 X on A/B while in_valid=0 SHALL not affect outputs.

Reset
REQ-019 rst_n low SHALL immediately (asynchronously) force C=0, S=0, out_valid=0, carry_cnt=0.
REQ-020 Reset release SHALL be synchronized internally (two-flop deassert synchronizer); first capture occurs no earlier than the second rising edge after rst_n rises.
REQ-021 Reset asserted mid-operation SHALL discard any in-flight result; no output glitches to a nonzero value during reset.

Configuration
REQ-022 Macro HALF_ADDER_CARRY_CNT_EN: when defined, carry_cnt port and a 16-bit counter SHALL exist.
REQ-023 With macro defined: counter SHALL increment by 1 on each edge where in_valid=1 and (A AND B) has any bit set; saturate at 16'hFFFF, no wrap.
REQ-024 With macro defined: carry_cnt SHALL update in the same edge as the corresponding C, reset to 0.
REQ-025 Without macro: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-026 WIDTH=1, reset then in_valid=1 with A,B = 00,10,11,01 on consecutive edges -> next-cycle C,S = 00,01,10,01, out_valid=1 each cycle.
REQ-027 WIDTH=8, A=8'hF0, B=8'h3C valid -> S=8'hCC, C=8'h30 one cycle later.
REQ-028 Valid result 11 (C=1,S=0), then in_valid=0 with A,B=00 -> out_valid=0, C=1, S=0 held.
REQ-029 Assert rst_n low between clock edges with out_valid=1 -> C, S, out_valid, carry_cnt go 0 immediately without a clock edge.
REQ-030 Macro defined, WIDTH=1: 3 valid cycles of A=B=1 then 1 of A=1,B=0 -> carry_cnt=3; preload near 16'hFFFF and drive further carries -> holds at 16'hFFFF.

Source files
------------

// File: rtl/half_adder.sv
// Registered per-bit half adder with a valid qualifier.
// Optional carry-event counter enabled by HALF_ADDER_CARRY_CNT_EN.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] S,
  output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [15:0]      carry_cnt
`endif
);

  logic [1:0]       r_rst_sync;
  logic             w_run;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  assign w_run   = r_rst_sync[1];
  assign w_sum   = A ^ B;
  assign w_carry = A & B;

  // Reset asserts at once but releases two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Capture sum/carry on valid input, hold them otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C         <= '0;
      S         <= '0;
      out_valid <= 1'b0;
    end else if (w_run) begin
      out_valid <= in_valid;
      if (in_valid) begin
        C <= w_carry;
        S <= w_sum;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0] r_carry_cnt;
  logic        w_carry_evt;

  assign w_carry_evt = in_valid & (|w_carry);
  assign carry_cnt   = r_carry_cnt;

  // Count accepted inputs that produce any carry, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= 16'h0000;
    end else if (w_run && w_carry_evt &&
                 (r_carry_cnt != 16'hFFFF)) begin
      r_carry_cnt <= r_carry_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: WIDTH=1 and WIDTH=8 instances vs reference model.
// Counter checks compiled in when HALF_ADDER_CARRY_CNT_EN is defined.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, v1;
  logic       c1, s1, ov1;
  logic [7:0] a8, b8, c8, s8;
  logic       v8, ov8;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] e_c1, e_s1, e_c8, e_s8;
  logic        e_ov1, e_ov8;
  int          e_cnt1, e_cnt8;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .A(a1), .B(b1), .in_valid(v1),
    .C(c1), .S(s1), .out_valid(ov1)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt1)
`endif
  );

  half_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .A(a8), .B(b8), .in_valid(v8),
    .C(c8), .S(s8), .out_valid(ov8)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_cnt(cnt8)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Column-wise addition of two bits per position: sum digit and carry
  function automatic void ref_add(input int w,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] c,
                                  output logic [31:0] s);
    int t;
    c = '0;
    s = '0;
    for (int i = 0; i < w; i++) begin
      t = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
  endfunction

  task automatic model_clear();
    e_c1 = '0; e_s1 = '0; e_ov1 = 1'b0;
    e_c8 = '0; e_s8 = '0; e_ov8 = 1'b0;
    e_cnt1 = 0; e_cnt8 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".c1"}, {31'd0, c1}, e_c1);
    chk({tag, ".s1"}, {31'd0, s1}, e_s1);
    chk({tag, ".ov1"}, {31'd0, ov1}, {31'd0, e_ov1});
    chk({tag, ".c8"}, {24'd0, c8}, e_c8);
    chk({tag, ".s8"}, {24'd0, s8}, e_s8);
    chk({tag, ".ov8"}, {31'd0, ov8}, {31'd0, e_ov8});
`ifdef HALF_ADDER_CARRY_CNT_EN
    chk({tag, ".cnt1"}, {16'd0, cnt1}, e_cnt1);
    chk({tag, ".cnt8"}, {16'd0, cnt8}, e_cnt8);
`endif
  endtask

  task automatic tick(input string tag);
    logic [31:0] c, s;
    @(posedge clk);
    #1;
    if (v1) begin
      ref_add(1, {31'd0, a1}, {31'd0, b1}, c, s);
      e_c1 = c; e_s1 = s; e_ov1 = 1'b1;
      if (c != 0 && e_cnt1 < 65535) e_cnt1++;
    end else begin
      e_ov1 = 1'b0;
    end
    if (v8) begin
      ref_add(8, {24'd0, a8}, {24'd0, b8}, c, s);
      e_c8 = c; e_s8 = s; e_ov8 = 1'b1;
      if (c != 0 && e_cnt8 < 65535) e_cnt8++;
    end else begin
      e_ov8 = 1'b0;
    end
    check_all(tag);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    check_all("sync1");
    v1 = 1'b0; v8 = 1'b0;
    @(posedge clk);
    #1;
    check_all("sync2");
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    #2;
    release_reset();
  endtask

  initial begin
    logic [1:0] pa [4];
    pa[0] = 2'b00; pa[1] = 2'b10; pa[2] = 2'b11; pa[3] = 2'b01;

    hard_reset();

    for (int i = 0; i < 4; i++) begin
      a1 = pa[i][1]; b1 = pa[i][0]; v1 = 1'b1;
      v8 = 1'b0;
      tick("seq");
    end

    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    tick("f0_3c");
    chk("s8_cc", {24'd0, s8}, 32'hCC);
    chk("c8_30", {24'd0, c8}, 32'h30);

    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; v8 = 1'b0;
    tick("hold");
    chk("hold_c1", {31'd0, c1}, 32'd1);
    chk("hold_s1", {31'd0, s1}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      v1 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    a8 = 8'h81; b8 = 8'h18; v8 = 1'b1;
    tick("pre_mid");
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("mid_rst");
    @(posedge clk);
    #1;
    check_all("mid_rst_edge");
    #2;
    release_reset();

`ifdef HALF_ADDER_CARRY_CNT_EN
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1; v8 = 1'b0;
    repeat (3) tick("cnt_c");
    b1 = 1'b0;
    tick("cnt_nc");
    chk("cnt_is3", {16'd0, cnt1}, 32'd3);
    b1 = 1'b1;
    repeat (65540) tick("cnt_sat");
    chk("cnt_ffff", {16'd0, cnt1}, 32'hFFFF);
`endif

    for (int i = 0; i < 20; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); v8 = 1'b1;
      tick("b2b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
